// File: rtl/ahb_master_ctrl.sv
// ---------------------------------------------------------------------------
// ahb_master_ctrl
//
// Sequencing front end for an AHB master port. Accepts one CPU load/store at
// a time and walks it through bus request/grant, the address phase and the
// data phase, then returns read data and error status to the CPU with a
// single-cycle completion pulse. No bursts, no address/data pipelining.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  CPU request and payload (held until accepted)
//   cpu_ready            high in IDLE only; accept = cpu_req & cpu_ready
//   cpu_rvalid           one-cycle completion pulse
//   cpu_rdata, cpu_err   completion data / error, meaningful with cpu_rvalid
//   haddr_o, haddr_ctrl_o, hwrite_o, hwdata_o, hbusreq_o
//                        stimulus towards the AHB master port
//   hgrant               arbiter grant
//   hready_s2m, hresp_s2m, hdata_s2m
//                        slave ready, response (1 = ERROR) and read data
// ---------------------------------------------------------------------------
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_master_ctrl #(
  parameter int ADDR_W  = `AHB_ADDR_WIDTH,
  parameter int DATA_W  = `AHB_DATA_WIDTH,
  parameter int TIMEOUT = 16              // data-phase wait limit, 1..255
) (
  input  logic              clk,
  input  logic              rstn,
  // CPU side
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  // AHB master stimulus
  output logic [ADDR_W-1:0] haddr_o,
  output logic              haddr_ctrl_o,
  output logic              hwrite_o,
  output logic [DATA_W-1:0] hwdata_o,
  output logic              hbusreq_o,
  // AHB return path
  input  logic              hgrant,
  input  logic              hready_s2m,
  input  logic              hresp_s2m,
  input  logic [DATA_W-1:0] hdata_s2m
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic                we_q,       we_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic                err_q,      err_d;
  logic [DATA_W-1:0]   rdata_q,    rdata_d;

  // -------------------------------------------------------------------------
  // Next-state and datapath register updates
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        // cpu_ready is 1 here, so cpu_req alone is an acceptance.
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (hgrant) state_d = S_ADDR;
      end

      S_ADDR: begin
        // Losing the grant outranks a ready slave: reissue the address phase.
        if (!hgrant) begin
          state_d = S_REQ;
        end else if (hready_s2m) begin
          state_d    = S_DATA;
          wait_cnt_d = '0;
        end
      end

      S_DATA: begin
        if (hready_s2m) begin
          err_d   = hresp_s2m;
          rdata_d = (!we_q && !hresp_s2m) ? hdata_s2m : '0;
          state_d = S_RESP;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          // TIMEOUT waits already counted: abort as an error.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and holding registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // -------------------------------------------------------------------------
  always_comb begin
    cpu_ready    = 1'b0;
    cpu_rvalid   = 1'b0;
    cpu_rdata    = '0;
    cpu_err      = 1'b0;
    haddr_o      = '0;
    haddr_ctrl_o = 1'b0;
    hwrite_o     = 1'b0;
    hwdata_o     = '0;
    hbusreq_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cpu_ready = 1'b1;
      end
      S_REQ: begin
        hbusreq_o = 1'b1;
      end
      S_ADDR: begin
        hbusreq_o    = 1'b1;
        haddr_ctrl_o = 1'b1;
        haddr_o      = addr_q;
        hwrite_o     = we_q;
      end
      S_DATA: begin
        // Address and direction stay on the bus through the data phase.
        haddr_o  = addr_q;
        hwrite_o = we_q;
        hwdata_o = we_q ? wdata_q : '0;
      end
      S_RESP: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = rdata_q;
        cpu_err    = err_q;
      end
      default: begin
        cpu_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_ctrl
//
// Directed bench for ahb_master_ctrl (32-bit address/data, TIMEOUT = 4).
// Each table row is one clock cycle: inputs driven for that cycle plus the
// outputs expected in that cycle. Timeout and mid-transfer reset are written
// out by hand below the table.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ahb_master_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_err;
  logic [AW-1:0] haddr_o;
  logic          haddr_ctrl_o;
  logic          hwrite_o;
  logic [DW-1:0] hwdata_o;
  logic          hbusreq_o;
  logic          hgrant = 1'b0;
  logic          hready_s2m = 1'b0;
  logic          hresp_s2m = 1'b0;
  logic [DW-1:0] hdata_s2m = '0;

  ahb_master_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ready   (cpu_ready),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .cpu_err     (cpu_err),
    .haddr_o     (haddr_o),
    .haddr_ctrl_o(haddr_ctrl_o),
    .hwrite_o    (hwrite_o),
    .hwdata_o    (hwdata_o),
    .hbusreq_o   (hbusreq_o),
    .hgrant      (hgrant),
    .hready_s2m  (hready_s2m),
    .hresp_s2m   (hresp_s2m),
    .hdata_s2m   (hdata_s2m)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ready;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;
    logic [AW-1:0] haddr;
    logic          hctrl;
    logic          hwrite;
    logic [DW-1:0] hwdata;
    logic          hbusreq;
  } out_t;

  typedef struct {
    string         name;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rdy;
    logic          resp;
    logic [DW-1:0] hdata;
    logic          care;   // address/direction/wdata checked this cycle
    out_t          exp;
  } vec_t;

  out_t outs;
  assign outs = {cpu_ready, cpu_rvalid, cpu_rdata, cpu_err, haddr_o,
                 haddr_ctrl_o, hwrite_o, hwdata_o, hbusreq_o};

  vec_t vecs[$];
  int   tests  = 0;
  int   errors = 0;
  out_t o_idle, o_req, full_m;

  function automatic out_t mk(logic ready, logic rvalid, logic [DW-1:0] rdata,
                              logic err, logic [AW-1:0] haddr, logic hctrl,
                              logic hwrite, logic [DW-1:0] hwdata,
                              logic hbusreq);
    out_t o;
    o.ready   = ready;
    o.rvalid  = rvalid;
    o.rdata   = rdata;
    o.err     = err;
    o.haddr   = haddr;
    o.hctrl   = hctrl;
    o.hwrite  = hwrite;
    o.hwdata  = hwdata;
    o.hbusreq = hbusreq;
    return o;
  endfunction

  // Bus address/direction/wdata are only defined during ADDR and DATA.
  function automatic out_t care_mask(logic care);
    out_t m;
    m = '1;
    if (!care) begin
      m.haddr  = '0;
      m.hwrite = 1'b0;
      m.hwdata = '0;
    end
    return m;
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp,
                       input out_t m);
    tests++;
    if ((act & m) !== (exp & m)) begin
      errors++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, m);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic req, input logic we,
                     input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic gnt, input logic rdy, input logic resp,
                     input logic [DW-1:0] hdata, input logic care,
                     input out_t exp);
    vec_t v;
    v.name = n;  v.req = req;  v.we = we;  v.addr = addr;  v.wdata = wdata;
    v.gnt = gnt; v.rdy = rdy;  v.resp = resp; v.hdata = hdata;
    v.care = care; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic gnt,
                       input logic rdy, input logic resp,
                       input logic [DW-1:0] hdata);
    cpu_req = req;  cpu_we = we;  cpu_addr = addr;  cpu_wdata = wdata;
    hgrant = gnt;   hready_s2m = rdy;  hresp_s2m = resp;  hdata_s2m = hdata;
  endtask

  initial begin
    int cnt;
    logic saw_rvalid;

    o_idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    o_req  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    full_m = care_mask(1'b1);

    // Read, ideal bus: ADDR in cycle 2, completion in cycle 4.
    add("rd_c0_accept", 1, 0, 'h1000, 0, 1, 1, 0, 'hDEADBEEF, 0, o_idle);
    add("rd_c1_req",    0, 0, 0, 0, 1, 1, 0, 'hDEADBEEF, 0, o_req);
    add("rd_c2_addr",   0, 0, 0, 0, 1, 1, 0, 'hDEADBEEF, 1, mk(0, 0, 0, 0, 'h1000, 1, 0, 0, 1));
    add("rd_c3_data",   0, 0, 0, 0, 1, 1, 0, 'hDEADBEEF, 1, mk(0, 0, 0, 0, 'h1000, 0, 0, 0, 0));
    add("rd_c4_resp",   0, 0, 0, 0, 1, 1, 0, 'hDEADBEEF, 0, mk(0, 1, 'hDEADBEEF, 0, 0, 0, 0, 0, 0));
    add("rd_c5_idle",   0, 0, 0, 0, 1, 1, 0, 'hDEADBEEF, 0, o_idle);
    // Write with three grant-wait cycles: completion in cycle 7, rdata 0.
    add("wr_c0_accept", 1, 1, 'h20, 'hA5A50001, 0, 1, 0, 'h12345678, 0, o_idle);
    add("wr_c1_req",    0, 0, 0, 0, 0, 1, 0, 'h12345678, 0, o_req);
    add("wr_c2_req",    0, 0, 0, 0, 0, 1, 0, 'h12345678, 0, o_req);
    add("wr_c3_req",    0, 0, 0, 0, 0, 1, 0, 'h12345678, 0, o_req);
    add("wr_c4_req_gnt",0, 0, 0, 0, 1, 1, 0, 'h12345678, 0, o_req);
    add("wr_c5_addr",   0, 0, 0, 0, 1, 1, 0, 'h12345678, 1, mk(0, 0, 0, 0, 'h20, 1, 1, 0, 1));
    add("wr_c6_data",   0, 0, 0, 0, 1, 1, 0, 'h12345678, 1, mk(0, 0, 0, 0, 'h20, 0, 1, 'hA5A50001, 0));
    add("wr_c7_resp",   0, 0, 0, 0, 1, 1, 0, 'h12345678, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add("wr_c8_idle",   0, 0, 0, 0, 1, 1, 0, 'h12345678, 0, o_idle);
    // Two slave wait states in DATA (hresp ignored while not ready).
    add("ws_c0_accept", 1, 0, 'h44, 0, 1, 1, 0, 'h0BADF00D, 0, o_idle);
    add("ws_c1_req",    0, 0, 0, 0, 1, 1, 0, 'h0BADF00D, 0, o_req);
    add("ws_c2_addr",   0, 0, 0, 0, 1, 1, 0, 'h0BADF00D, 1, mk(0, 0, 0, 0, 'h44, 1, 0, 0, 1));
    add("ws_c3_wait",   0, 0, 0, 0, 1, 0, 1, 'h0BADF00D, 1, mk(0, 0, 0, 0, 'h44, 0, 0, 0, 0));
    add("ws_c4_wait",   0, 0, 0, 0, 1, 0, 1, 'h0BADF00D, 1, mk(0, 0, 0, 0, 'h44, 0, 0, 0, 0));
    add("ws_c5_data",   0, 0, 0, 0, 1, 1, 0, 'h0BADF00D, 1, mk(0, 0, 0, 0, 'h44, 0, 0, 0, 0));
    add("ws_c6_resp",   0, 0, 0, 0, 1, 1, 0, 'h0BADF00D, 0, mk(0, 1, 'h0BADF00D, 0, 0, 0, 0, 0, 0));
    add("ws_c7_idle",   0, 0, 0, 0, 1, 1, 0, 'h0BADF00D, 0, o_idle);
    // One ADDR stall cycle on a write.
    add("as_c0_accept", 1, 1, 'h30, 'h0F0F0F0F, 1, 1, 0, 0, 0, o_idle);
    add("as_c1_req",    0, 0, 0, 0, 1, 1, 0, 0, 0, o_req);
    add("as_c2_stall",  0, 0, 0, 0, 1, 0, 0, 0, 1, mk(0, 0, 0, 0, 'h30, 1, 1, 0, 1));
    add("as_c3_addr",   0, 0, 0, 0, 1, 1, 0, 0, 1, mk(0, 0, 0, 0, 'h30, 1, 1, 0, 1));
    add("as_c4_data",   0, 0, 0, 0, 1, 1, 0, 0, 1, mk(0, 0, 0, 0, 'h30, 0, 1, 'h0F0F0F0F, 0));
    add("as_c5_resp",   0, 0, 0, 0, 1, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add("as_c6_idle",   0, 0, 0, 0, 1, 1, 0, 0, 0, o_idle);
    // Error response, request ignored in RESP, next one accepted right after.
    add("er_c0_accept", 1, 0, 'h80, 0, 1, 1, 0, 'hFFFFFFFF, 0, o_idle);
    add("er_c1_req",    0, 0, 0, 0, 1, 1, 0, 'hFFFFFFFF, 0, o_req);
    add("er_c2_addr",   0, 0, 0, 0, 1, 1, 0, 'hFFFFFFFF, 1, mk(0, 0, 0, 0, 'h80, 1, 0, 0, 1));
    add("er_c3_data",   0, 0, 0, 0, 1, 1, 1, 'hFFFFFFFF, 1, mk(0, 0, 0, 0, 'h80, 0, 0, 0, 0));
    add("er_c4_resp",   1, 0, 'h99, 'h77, 1, 1, 0, 'hFFFFFFFF, 0, mk(0, 1, 0, 1, 0, 0, 0, 0, 0));
    add("er_c5_accept", 1, 1, 'h84, 'h55, 1, 1, 0, 'h13579BDF, 0, o_idle);
    add("er_c6_req",    0, 0, 0, 0, 1, 1, 0, 'h13579BDF, 0, o_req);
    add("er_c7_addr",   0, 0, 0, 0, 1, 1, 0, 'h13579BDF, 1, mk(0, 0, 0, 0, 'h84, 1, 1, 0, 1));
    add("er_c8_data",   0, 0, 0, 0, 1, 1, 0, 'h13579BDF, 1, mk(0, 0, 0, 0, 'h84, 0, 1, 'h55, 0));
    add("er_c9_resp",   0, 0, 0, 0, 1, 1, 0, 'h13579BDF, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    add("er_c10_idle",  0, 0, 0, 0, 1, 1, 0, 'h13579BDF, 0, o_idle);

    // ---------------- reset state ----------------
    #2 rstn = 1'b0;
    #1 check("reset_state", outs, o_idle, full_m);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    next_cycle();

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
            vecs[i].gnt, vecs[i].rdy, vecs[i].resp, vecs[i].hdata);
      check(vecs[i].name, outs, vecs[i].exp, care_mask(vecs[i].care));
      next_cycle();
    end

    // ---------------- timeout (TIMEOUT = 4) ----------------
    drive(1, 0, 'hC0, 0, 1, 1, 0, 'hCAFE0000);
    check("to_accept", outs, o_idle, full_m);
    next_cycle();
    drive(0, 0, 0, 0, 1, 1, 0, 'hCAFE0000);
    next_cycle();
    check("to_addr", outs, mk(0, 0, 0, 0, 'hC0, 1, 0, 0, 1), full_m);
    next_cycle();
    hready_s2m = 1'b0;   // DATA entered this cycle; slave never ready
    cnt = 0;
    while (!cpu_rvalid && cnt < 20) begin
      next_cycle();
      cnt++;
    end
    check_int("to_latency", cnt, 5);
    check("to_resp", outs, mk(0, 1, 0, 1, 0, 0, 0, 0, 0), full_m);
    hready_s2m = 1'b1;
    next_cycle();
    check("to_idle", outs, o_idle, full_m);

    // ---------------- grant drop in ADDR, then reset in DATA ----------------
    drive(1, 0, 'h100, 0, 1, 1, 0, 'h11112222);
    next_cycle();
    drive(0, 0, 0, 0, 1, 1, 0, 'h11112222);
    next_cycle();
    check("gd_addr", outs, mk(0, 0, 0, 0, 'h100, 1, 0, 0, 1), full_m);
    hgrant = 1'b0;       // drop grant while slave is ready
    next_cycle();
    check("gd_back_to_req", outs, o_req, full_m);
    hgrant = 1'b1;
    next_cycle();
    check("gd_reissue_addr", outs, mk(0, 0, 0, 0, 'h100, 1, 0, 0, 1), full_m);
    next_cycle();
    hready_s2m = 1'b0;
    check("gd_data", outs, mk(0, 0, 0, 0, 'h100, 0, 0, 0, 0), full_m);
    #2 rstn = 1'b0;
    #1 check("rst_mid_data", outs, o_idle, full_m);
    hready_s2m = 1'b1;
    @(negedge clk) rstn = 1'b1;
    saw_rvalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      if (cpu_rvalid) saw_rvalid = 1'b1;
    end
    check_int("rst_no_rvalid", int'(saw_rvalid), 0);
    check("rst_idle_after", outs, o_idle, full_m);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/ahb_master_ctrl.md
# ahb_master_ctrl

Sequencing front end for the AHB `master` port. It accepts single load/store requests from the CPU-side bus interface and runs the AHB request/grant, address-phase and data-phase sequence, driving the `master` stimulus inputs (`haddr_i`, `haddr_ctrl_i`, `hwrite_i`, `hwdata_i`, `hbusreq_i`). It consumes the slave return signals and hands read data and error status back to the CPU. One transfer is in flight at a time, with no bursts and no pipelining of the address and data phases.

## Interface
- `ADDR_W`, default `AHB_ADDR_WIDTH`: address width.
- `DATA_W`, default `AHB_DATA_WIDTH`: data width.
- `TIMEOUT`, default 16: maximum number of data-phase wait cycles before the transfer is aborted. Legal range is 1..255.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU transfer request, held with its payload until accepted.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  transfer address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_ready`  out  1  block can accept a request. A request is accepted on the cycle where `cpu_req & cpu_ready`.
- `cpu_rvalid`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read data. Valid while `cpu_rvalid` is high; 0 for writes and errors.
- `cpu_err`  out  1  error flag, valid with `cpu_rvalid`.
- `haddr_o`  out  ADDR_W  drives `haddr_i` of `master`.
- `haddr_ctrl_o`  out  1  address-phase valid; drives `haddr_ctrl_i`.
- `hwrite_o`  out  1  drives `hwrite_i`.
- `hwdata_o`  out  DATA_W  drives `hwdata_i`.
- `hbusreq_o`  out  1  drives `hbusreq_i`.
- `hgrant`  in  1  grant from the arbiter.
- `hready_s2m`  in  1  slave ready.
- `hresp_s2m`  in  1  slave response; 1 = ERROR.
- `hdata_s2m`  in  DATA_W  slave read data.

## Operation
- The FSM has five states: IDLE, REQ, ADDR, DATA, RESP. State and all outputs are registered or decoded from registered state.
- **IDLE**
  - `cpu_ready`=1.
  - On acceptance, latch `cpu_addr`, `cpu_we` and `cpu_wdata` into holding registers, then go to REQ.
- **REQ**
  - `hbusreq_o`=1.
  - If `hgrant`=1, go to ADDR. Otherwise stay.
- **ADDR**
  - Outputs: `hbusreq_o`=1, `haddr_ctrl_o`=1, `haddr_o`=latched address, `hwrite_o`=latched we.
  - If `hgrant`=0, return to REQ (grant lost; the address phase is reissued).
  - Else if `hready_s2m`=1, go to DATA and clear the wait counter.
  - Else stay.
- **DATA**
  - Outputs: `hbusreq_o`=0, `haddr_ctrl_o`=0, `hwdata_o`=latched wdata when we=1 (0 otherwise).
  - The address and `hwrite_o` hold their last values.
  - If `hready_s2m`=1, do all of the following, then go to RESP:
    - capture `hresp_s2m` into the error register;
    - if read and no error, capture `hdata_s2m`;
    - if write or error, load 0 into the read-data register.
  - Else increment the 8-bit wait counter. When the counter reaches `TIMEOUT`, go to RESP with error=1 and rdata=0.
- **RESP**
  - `cpu_rvalid`=1, with `cpu_rdata` and `cpu_err` taken from the registers.
  - Unconditionally return to IDLE.
- Only one transfer is outstanding. `cpu_ready`=0 in every state except IDLE, so back-to-back requests each pay the full sequence.

## Timing
- **Reset values** (all asynchronous on `rstn`=0):
  - state = IDLE, so `cpu_ready`=1;
  - every other output = 0;
  - holding registers, wait counter, error and rdata registers = 0.
- **Reset mid-transfer** returns to IDLE immediately. The transfer is dropped and no `cpu_rvalid` is produced.
- **Best-case latency** (`hgrant` and `hready_s2m` held at 1), with acceptance at cycle 0:
  - REQ in cycle 1;
  - ADDR in cycle 2;
  - DATA in cycle 3;
  - RESP, with `cpu_rvalid`, in cycle 4.
- Each cycle of grant wait, ADDR stall or DATA wait adds exactly one cycle.
- **Timeout:** with `hready_s2m` stuck at 0 in DATA, `cpu_rvalid` with `cpu_err`=1 appears `TIMEOUT`+1 cycles after DATA is entered.
- **Grant lost in ADDR:** grant loss has priority over `hready_s2m` in the same cycle. The block goes to REQ with no data phase.
- **Error on ready:** `hresp_s2m`=1 together with `hready_s2m`=1 in DATA gives `cpu_err`=1 and `cpu_rdata`=0. `hresp_s2m` is ignored while `hready_s2m`=0.
- **`cpu_req` outside IDLE** is ignored and has no side effects.

## Test plan
- **Read, ideal bus:** with `hgrant`=1, `hready_s2m`=1 and `hdata_s2m`=0xDEADBEEF, issue a read of 0x0000_1000.
  - `haddr_ctrl_o`=1 with `haddr_o`=0x1000 in cycle 2.
  - `cpu_rvalid`=1 with `cpu_rdata`=0xDEADBEEF and `cpu_err`=0 in cycle 4.
- **Write, grant delayed:** `hgrant` stays 0 for 3 cycles, then rises. Write 0xA5A5_0001 to 0x20.
  - `hbusreq_o` stays high through REQ.
  - `hwdata_o`=0xA5A50001 in DATA.
  - `cpu_rvalid` in cycle 7 with `cpu_rdata`=0.
- **Slave wait states:** `hready_s2m`=0 for 2 DATA cycles.
  - Completion is 2 cycles later than best case.
  - `hbusreq_o`=0 throughout DATA.
- **Error response:** `hresp_s2m`=1 with `hready_s2m`=1 in DATA.
  - `cpu_err`=1 and `cpu_rdata`=0.
  - Next request is accepted the cycle after RESP.
- **Timeout:** with `TIMEOUT`=4, `hready_s2m` stuck at 0 in DATA.
  - `cpu_err`=1 appears 5 cycles after DATA entry.
- **Grant drop and reset:** drop `hgrant` in ADDR.
  - The block returns to REQ and `haddr_ctrl_o` falls.
  - Then assert `rstn`=0 in DATA: all outputs are 0 and `cpu_ready`=1 immediately, with no `cpu_rvalid`.
